regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Controller in front of the core's register file single write port.
- Shares that port between two writeback requesters (A = ALU, B = load/store unit) using a valid/ready handshake and 2-way round-robin arbitration.
- Sequences a zero-clear sweep of every register after reset and on request.
- Drives the register file's wr_enable/wr_addr/wr_data directly from registered outputs.

Parameters:
- DATA_WIDTH_P, 32, register width.
- ADDR_WIDTH_P, 5, register address width.
- DEPTH_P, 32, number of registers swept by a clear; must be ≤ 2^ADDR_WIDTH_P.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  active-low asynchronous reset.
- i_clear_start  in  1  one-cycle pulse: start a clear sweep; honoured only in RUN.
- o_clear_busy  out  1  high while state is CLEAR.
- i_a_valid  in  1  requester A has a write.
- i_a_addr  in  ADDR_WIDTH_P  requester A destination.
- i_a_data  in  DATA_WIDTH_P  requester A data.
- o_a_ready  out  1  A accepted this cycle when i_a_valid & o_a_ready.
- i_b_valid, i_b_addr, i_b_data, o_b_ready: same as A, for requester B.
- o_wr_enable  out  1  register file write enable.
- o_wr_addr  out  ADDR_WIDTH_P  register file write address.
- o_wr_data  out  DATA_WIDTH_P  register file write data.

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-low. Asserting it (0) immediately forces:
  - state = CLEAR, sweep counter = 0, rr_last = B;
  - o_wr_enable = 0, o_wr_addr = 0, o_wr_data = 0.
- States:
  - CLEAR (reset state): sweep zeros into the register file.
  - RUN: arbitrate requesters.
- CLEAR:
  - Each edge: o_wr_enable <= 1, o_wr_addr <= counter, o_wr_data <= 0, counter += 1.
  - The edge that issues address DEPTH_P-1 moves state to RUN and resets the counter to 0.
  - A sweep is therefore exactly DEPTH_P writes on DEPTH_P consecutive edges, addresses 0..DEPTH_P-1 ascending, with no gaps.
  - o_a_ready = o_b_ready = 0 throughout; i_clear_start is ignored.
- RUN, ready logic:
  - o_a_ready = i_a_valid path free: RUN & ~i_clear_start & (~i_b_valid | rr_last==B).
  - o_b_ready = RUN & ~i_clear_start & (~i_a_valid | rr_last==A).
  - Ready is combinational. Only one requester can handshake per cycle. A lone valid requester is always accepted.
- RUN, accepted write:
  - On an accepted handshake, the next edge sets o_wr_enable <= (addr != 0), o_wr_addr <= addr, o_wr_data <= data, and rr_last <= granted id.
  - Latency is 1 cycle from handshake to write visible on the port.
  - Throughput is 1 write per cycle.
- RUN, no handshake: next edge sets o_wr_enable <= 0; o_wr_addr and o_wr_data hold their values.
- x0 rule:
  - A write to address 0 is accepted (ready high, handshake completes, rr_last updates) but never asserts o_wr_enable.
  - The clear sweep does write address 0.
- Clear request in RUN:
  - i_clear_start high forces both readies to 0 that cycle, so no grant.
  - Next edge: state <= CLEAR, counter <= 0, o_wr_enable <= 0.
  - The sweep's first write (address 0) appears on the following edge.
- o_clear_busy = (state == CLEAR); it is 1 during and immediately after reset.
- Requesters must hold valid/addr/data stable until accepted. The block does not check this.
- Reset mid-sweep: the sweep aborts and restarts from address 0 after reset release.

Decomposition:
- Shared package/include regfile_ctrl_pkg holds:
  - state encodings ST_CLEAR = 1'b0, ST_RUN = 1'b1;
  - requester ids REQ_A = 1'b0, REQ_B = 1'b1;
  - default widths (32/5/32).
- One sub-module, rr_arbiter_2: a combinational 2-way round-robin grant from (valid_a, valid_b, last, enable).
- The rr_last register, the FSM and the sweep counter stay in the top level.

Test Plan:
- Release reset, requesters idle -> 32 consecutive edges with o_wr_enable=1, addr 0,1,…,31, data 0. o_clear_busy=1 for those cycles then 0. Both readies 0 throughout.
- After the sweep, A alone: addr 5, data 0xDEADBEEF -> o_a_ready=1. Next cycle o_wr_enable=1, addr 5, data 0xDEADBEEF. Following cycle o_wr_enable=0.
- A (addr 1, 0x11) and B (addr 2, 0x22) both held valid, each re-presented after acceptance -> grants A,B,A,B. Port shows addr 1,2,1,2 on consecutive cycles.
- B writes addr 0, data 0xFFFFFFFF -> o_b_ready=1, o_wr_enable stays 0. A then contends with B -> A wins (rr_last = B).
- i_clear_start pulsed while A is valid (addr 3) -> o_a_ready=0 that cycle. Sweep addr 0..31 follows. A is accepted the cycle after the sweep ends and its write lands one cycle later.
- Reset asserted while the sweep is at addr 10 -> o_wr_enable=0 asynchronously. After release, the sweep restarts at addr 0 and runs a full 32 writes.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Purpose: shared encodings and default widths for the register-file write-port controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_ctrl_pkg;

    // Default geometry of the core register file.
    localparam int DATA_WIDTH_D = 32;
    localparam int ADDR_WIDTH_D = 5;
    localparam int DEPTH_D      = 32;

    // Controller states: CLEAR is the reset state and sweeps zeros,
    // RUN arbitrates the writeback requesters.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Writeback requester identities (A = ALU, B = load/store unit).
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage : regfile_ctrl_pkg

// File: rtl/rr_arbiter_2.sv
// Purpose: combinational 2-way round-robin ready/grant for the register-file write port.
// Latency: 0 cycles (pure combinational).
// Backpressure: ready drops for the requester that won last time when both are valid; enable=0 drops both.
//
// Ports:
//   valid_a/valid_b   requester valids
//   last              requester granted most recently
//   enable            arbitration allowed this cycle
//   ready_a/ready_b   ready back to each requester (independent of its own valid)
//   grant_a/grant_b   handshake completes this cycle (valid & ready)
module rr_arbiter_2
    import regfile_ctrl_pkg::*;
(
    input  logic    valid_a,
    input  logic    valid_b,
    input  req_id_e last,
    input  logic    enable,
    output logic    ready_a,
    output logic    ready_b,
    output logic    grant_a,
    output logic    grant_b
);

    // A requester is ready when its competitor is idle or the competitor
    // was the previous winner. With both valid exactly one side is ready,
    // so at most one grant can fire per cycle.
    always_comb begin
        ready_a = enable & (~valid_b | (last == REQ_B));
        ready_b = enable & (~valid_a | (last == REQ_A));
        grant_a = valid_a & ready_a;
        grant_b = valid_b & ready_b;
    end

endmodule : rr_arbiter_2

// File: rtl/regfile_wb_arbiter.sv
// Purpose: owns the register file's single write port; arbitrates ALU/LSU writebacks and runs zero-clear sweeps.
// Latency: 1 cycle from accepted handshake to write on the port; 1 write per cycle sustained.
// Backpressure: both readies low during a sweep and in the cycle a clear is requested; otherwise round-robin.
//
// Ports:
//   clk, reset                 clock (rising edge) and asynchronous active-low reset
//   i_clear_start              one-cycle pulse requesting a clear sweep (honoured only in RUN)
//   o_clear_busy               high while the sweep state is active
//   i_a_* / o_a_ready          requester A (ALU) valid/addr/data and ready
//   i_b_* / o_b_ready          requester B (load/store) valid/addr/data and ready
//   o_wr_enable/addr/data      registered register-file write port
//
// DEPTH_P must not exceed 2**ADDR_WIDTH_P; the sweep counter is ADDR_WIDTH_P bits.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH_D,
    parameter int ADDR_WIDTH_P = ADDR_WIDTH_D,
    parameter int DEPTH_P      = DEPTH_D
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_clear_start,
    output logic                    o_clear_busy,

    input  logic                    i_a_valid,
    input  logic [ADDR_WIDTH_P-1:0] i_a_addr,
    input  logic [DATA_WIDTH_P-1:0] i_a_data,
    output logic                    o_a_ready,

    input  logic                    i_b_valid,
    input  logic [ADDR_WIDTH_P-1:0] i_b_addr,
    input  logic [DATA_WIDTH_P-1:0] i_b_data,
    output logic                    o_b_ready,

    output logic                    o_wr_enable,
    output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
    output logic [DATA_WIDTH_P-1:0] o_wr_data
);

    localparam logic [ADDR_WIDTH_P-1:0] LAST_ADDR = ADDR_WIDTH_P'(DEPTH_P - 1);

    state_e                  state;
    req_id_e                 rr_last;
    logic [ADDR_WIDTH_P-1:0] sweep_cnt;

    logic arb_enable;
    logic grant_a;
    logic grant_b;

    // A clear request steals the cycle so no writeback slips in ahead of the sweep.
    assign arb_enable   = (state == ST_RUN) & ~i_clear_start;
    assign o_clear_busy = (state == ST_CLEAR);

    rr_arbiter_2 u_rr_arbiter_2 (
        .valid_a (i_a_valid),
        .valid_b (i_b_valid),
        .last    (rr_last),
        .enable  (arb_enable),
        .ready_a (o_a_ready),
        .ready_b (o_b_ready),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_CLEAR;
            sweep_cnt   <= '0;
            rr_last     <= REQ_B;
            o_wr_enable <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // One zero write per edge, ascending, no gaps; the edge that
                    // issues the final address hands control back to RUN.
                    o_wr_enable <= 1'b1;
                    o_wr_addr   <= sweep_cnt;
                    o_wr_data   <= '0;
                    if (sweep_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (i_clear_start) begin
                        // Dead cycle on the port; the sweep's address 0 follows next edge.
                        state       <= ST_CLEAR;
                        sweep_cnt   <= '0;
                        o_wr_enable <= 1'b0;
                    end else if (grant_a) begin
                        // x0 is hardwired zero: the handshake completes but never writes.
                        o_wr_enable <= (i_a_addr != '0);
                        o_wr_addr   <= i_a_addr;
                        o_wr_data   <= i_a_data;
                        rr_last     <= REQ_A;
                    end else if (grant_b) begin
                        o_wr_enable <= (i_b_addr != '0);
                        o_wr_addr   <= i_b_addr;
                        o_wr_data   <= i_b_data;
                        rr_last     <= REQ_B;
                    end else begin
                        // Address/data hold so the port only toggles on real writes.
                        o_wr_enable <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: self-checking bench for regfile_wb_arbiter: directed sequences, a vector table and a randomized phase.
// Latency: n/a.
// Backpressure: requesters hold valid/addr/data until the reference model says they were accepted.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_clear_start;
    logic          o_clear_busy;
    logic          i_a_valid;
    logic [AW-1:0] i_a_addr;
    logic [DW-1:0] i_a_data;
    logic          o_a_ready;
    logic          i_b_valid;
    logic [AW-1:0] i_b_addr;
    logic [DW-1:0] i_b_data;
    logic          o_b_ready;
    logic          o_wr_enable;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;

    regfile_wb_arbiter #(
        .DATA_WIDTH_P (DW),
        .ADDR_WIDTH_P (AW),
        .DEPTH_P      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_clear_start (i_clear_start),
        .o_clear_busy  (o_clear_busy),
        .i_a_valid     (i_a_valid),
        .i_a_addr      (i_a_addr),
        .i_a_data      (i_a_data),
        .o_a_ready     (o_a_ready),
        .i_b_valid     (i_b_valid),
        .i_b_addr      (i_b_addr),
        .i_b_data      (i_b_data),
        .o_b_ready     (o_b_ready),
        .o_wr_enable   (o_wr_enable),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks what the spec says the port should show: whether a sweep is in
    // progress and which index it issues next, who won last, and the port.
    bit          m_clear;
    int          m_idx;
    bit          m_last_b;
    bit          m_en;
    int unsigned m_addr;
    int unsigned m_data;
    bit          m_ra, m_rb, m_busy, m_acc_a, m_acc_b;

    function automatic void model_reset();
        m_clear  = 1'b1;
        m_idx    = 0;
        m_last_b = 1'b1;
        m_en     = 1'b0;
        m_addr   = 0;
        m_data   = 0;
    endfunction

    function automatic void model_step(bit cs, bit av, int unsigned aa, int unsigned ad,
                                       bit bv, int unsigned ba, int unsigned bd);
        m_busy  = m_clear;
        m_ra    = !m_clear && !cs && (!bv || m_last_b);
        m_rb    = !m_clear && !cs && (!av || !m_last_b);
        m_acc_a = av && m_ra;
        m_acc_b = bv && m_rb;
        if (m_clear) begin
            m_en = 1'b1; m_addr = m_idx; m_data = 0;
            if (m_idx == DEPTH - 1) begin m_clear = 1'b0; m_idx = 0; end
            else m_idx++;
        end else if (cs) begin
            m_clear = 1'b1; m_idx = 0; m_en = 1'b0;
        end else if (m_acc_a) begin
            m_en = (aa != 0); m_addr = aa; m_data = ad; m_last_b = 1'b0;
        end else if (m_acc_b) begin
            m_en = (ba != 0); m_addr = ba; m_data = bd; m_last_b = 1'b1;
        end else begin
            m_en = 1'b0;
        end
    endfunction

    // One clock: drive at posedge+1, sample readies at negedge, sample port at posedge+1.
    task automatic cyc(input bit cs, input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       output bit ra, output bit rb, output bit bsy,
                       output bit en, output logic [AW-1:0] wa, output logic [DW-1:0] wd);
        i_clear_start = cs;
        i_a_valid = av; i_a_addr = aa; i_a_data = ad;
        i_b_valid = bv; i_b_addr = ba; i_b_data = bd;
        @(negedge clk);
        ra = o_a_ready; rb = o_b_ready; bsy = o_clear_busy;
        model_step(cs, av, aa, ad, bv, ba, bd);
        @(posedge clk);
        #1;
        en = o_wr_enable; wa = o_wr_addr; wd = o_wr_data;
    endtask

    typedef struct {
        bit cs; bit av; logic [AW-1:0] aa; logic [DW-1:0] ad;
        bit bv; logic [AW-1:0] ba; logic [DW-1:0] bd;
        bit xra; bit xrb; bit xen; logic [AW-1:0] xaddr; logic [DW-1:0] xdata;
    } vec_t;

    vec_t tbl[10];

    bit ra, rb, bsy, en;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    initial begin
        // Starting after a sweep, rr_last = B.
        //            cs av aa  ad            bv ba  bd            ra rb en addr data
        tbl[0] = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 5, 32'hDEADBEEF};
        tbl[1] = '{0, 0, 0, 0,            0, 0, 0,            1, 1, 0, 5, 32'hDEADBEEF};
        tbl[2] = '{0, 0, 0, 0,            1, 7, 32'h77,       0, 1, 1, 7, 32'h77};
        tbl[3] = '{0, 1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 1, 32'h11};
        tbl[4] = '{0, 1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 2, 32'h22};
        tbl[5] = '{0, 1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 1, 32'h11};
        tbl[6] = '{0, 1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 2, 32'h22};
        tbl[7] = '{0, 0, 0, 0,            1, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 32'hFFFFFFFF};
        tbl[8] = '{0, 1, 9, 32'h99,       1, 4, 32'h44,       1, 0, 1, 9, 32'h99};
        tbl[9] = '{1, 1, 3, 32'h33,       0, 0, 0,            0, 0, 0, 9, 32'h99};

        reset = 1'b0;
        i_clear_start = 0; i_a_valid = 0; i_a_addr = 0; i_a_data = 0;
        i_b_valid = 0; i_b_addr = 0; i_b_data = 0;
        model_reset();
        #1;
        chk("rst_en",   o_wr_enable, 0);
        chk("rst_addr", o_wr_addr, 0);
        chk("rst_data", o_wr_data, 0);
        chk("rst_busy", o_clear_busy, 1);
        chk("rst_ra",   o_a_ready, 0);
        chk("rst_rb",   o_b_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Power-on sweep.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
            chk($sformatf("sweep0_ra[%0d]", i), ra, 0);
            chk($sformatf("sweep0_rb[%0d]", i), rb, 0);
            chk($sformatf("sweep0_busy[%0d]", i), bsy, 1);
            chk($sformatf("sweep0_en[%0d]", i), en, 1);
            chk($sformatf("sweep0_addr[%0d]", i), wa, i);
            chk($sformatf("sweep0_data[%0d]", i), wd, 0);
        end

        // Vector table: single writes, round-robin contention, x0 rule, clear request.
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].cs, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
                ra, rb, bsy, en, wa, wd);
            chk($sformatf("vec%0d_ra", i), ra, tbl[i].xra);
            chk($sformatf("vec%0d_rb", i), rb, tbl[i].xrb);
            chk($sformatf("vec%0d_busy", i), bsy, 0);
            chk($sformatf("vec%0d_en", i), en, tbl[i].xen);
            chk($sformatf("vec%0d_addr", i), wa, tbl[i].xaddr);
            chk($sformatf("vec%0d_data", i), wd, tbl[i].xdata);
        end

        // Sweep triggered by the clear request, A (addr 3) held valid throughout.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 3, 32'h33, 0, 0, 0, ra, rb, bsy, en, wa, wd);
            chk($sformatf("sweep1_ra[%0d]", i), ra, 0);
            chk($sformatf("sweep1_busy[%0d]", i), bsy, 1);
            chk($sformatf("sweep1_en[%0d]", i), en, 1);
            chk($sformatf("sweep1_addr[%0d]", i), wa, i);
            chk($sformatf("sweep1_data[%0d]", i), wd, 0);
        end
        cyc(0, 1, 3, 32'h33, 0, 0, 0, ra, rb, bsy, en, wa, wd);
        chk("post_sweep_ra", ra, 1);
        chk("post_sweep_busy", bsy, 0);
        chk("post_sweep_en", en, 1);
        chk("post_sweep_addr", wa, 3);
        chk("post_sweep_data", wd, 32'h33);
        cyc(0, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
        chk("post_sweep_idle_en", en, 0);
        chk("post_sweep_idle_addr", wa, 3);

        // Randomized traffic against the reference model.
        begin
            bit pa = 0, pb = 0, cs;
            logic [AW-1:0] aa = 0, ba = 0;
            logic [DW-1:0] ad = 0, bd = 0;
            for (int c = 0; c < 400; c++) begin
                if (!pa && $urandom_range(0, 2) != 0) begin
                    pa = 1; aa = AW'($urandom); ad = $urandom;
                end
                if (!pb && $urandom_range(0, 2) != 0) begin
                    pb = 1; ba = AW'($urandom); bd = $urandom;
                end
                cs = !m_clear && ($urandom_range(0, 39) == 0);
                cyc(cs, pa, aa, ad, pb, ba, bd, ra, rb, bsy, en, wa, wd);
                chk($sformatf("rnd%0d_ra", c), ra, m_ra);
                chk($sformatf("rnd%0d_rb", c), rb, m_rb);
                chk($sformatf("rnd%0d_busy", c), bsy, m_busy);
                chk($sformatf("rnd%0d_en", c), en, m_en);
                chk($sformatf("rnd%0d_addr", c), wa, m_addr);
                chk($sformatf("rnd%0d_data", c), wd, m_data);
                if (m_acc_a) pa = 0;
                if (m_acc_b) pb = 0;
            end
        end

        // Reset asserted while the sweep sits at address 10.
        for (int i = 0; i < 2 * DEPTH && m_clear; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
        chk("pre_clear_in_run", m_clear, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
        chk("clr_req_en", en, 0);
        for (int i = 0; i <= 10; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
        chk("mid_sweep_en", en, 1);
        chk("mid_sweep_addr", wa, 10);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_en", o_wr_enable, 0);
        chk("async_rst_addr", o_wr_addr, 0);
        chk("async_rst_busy", o_clear_busy, 1);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
            chk($sformatf("sweep2_busy[%0d]", i), bsy, 1);
            chk($sformatf("sweep2_en[%0d]", i), en, 1);
            chk($sformatf("sweep2_addr[%0d]", i), wa, i);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, ra, rb, bsy, en, wa, wd);
        chk("sweep2_done_busy", bsy, 0);
        chk("sweep2_done_en", en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
